// File: rtl/keccak_absorb_seq_if.sv
// keccak_absorb_seq_if
// Bundles the two buses the absorb sequencer talks over: the read port of
// the dual-clock input FIFO and the word-write/permute port of the Keccak
// absorb core. Both live in the FIFO read clock domain.
//
//   fifordy   : FIFO has a word available
//   fifoget   : read request, one word per asserted cycle
//   fifovld   : read data valid, one cycle after fifoget
//   fifodout  : read data
//   fiforderr : FIFO read-side error
//   flush     : one-cycle FIFO flush pulse after an error abort
//   core_wr   : write core_dat into rate buffer word core_wa
//   core_wa   : rate buffer word index
//   core_dat  : word to absorb
//   core_go   : XOR rate buffer into state and permute
//   core_last : qualifies core_go, final block of the message
//   core_busy : core is permuting
//
// master = sequencer side, slave = FIFO/core side.
interface keccak_absorb_seq_if #(
    parameter int WA_W = 6
);
    logic            fifordy;
    logic            fifoget;
    logic            fifovld;
    logic [31:0]     fifodout;
    logic            fiforderr;
    logic            flush;
    logic            core_wr;
    logic [WA_W-1:0] core_wa;
    logic [31:0]     core_dat;
    logic            core_go;
    logic            core_last;
    logic            core_busy;

    modport master (
        input  fifordy, fifovld, fifodout, fiforderr, core_busy,
        output fifoget, flush, core_wr, core_wa, core_dat, core_go, core_last
    );

    modport slave (
        output fifordy, fifovld, fifodout, fiforderr, core_busy,
        input  fifoget, flush, core_wr, core_wa, core_dat, core_go, core_last
    );
endinterface

// File: rtl/keccak_absorb_seq.sv
// keccak_absorb_seq
// Read-side sequencer between the input FIFO and the Keccak absorb core.
// On start it pulls msg_words 32-bit words out of the FIFO, writes them into
// the core rate buffer word by word, appends SHA-3 word-granular padding and
// fires one permutation per rate block.
//
//   rdclk, rdrst : FIFO read clock, async active-high reset
//   start        : one-cycle hash request, only honoured when idle
//   msg_words    : message length in words, sampled with start
//   busy         : high from accepted start until done or error abort
//   done         : one-cycle pulse after the final block has been fired
//   err          : sticky FIFO read error, cleared by the next start
//   bus          : FIFO read port and core write/permute port
module keccak_absorb_seq #(
    parameter int          RATE_WORDS = 34,
    parameter int          WA_W       = 6,
    parameter int          LEN_W      = 16,
    parameter logic [31:0] DS_PAD     = 32'h00000006
) (
    input  logic                  rdclk,
    input  logic                  rdrst,
    input  logic                  start,
    input  logic [LEN_W-1:0]      msg_words,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    keccak_absorb_seq_if.master   bus
);

    typedef enum logic [2:0] {IDLE, FILL, PAD, FIRE, WAITC} state_t;

    localparam logic [WA_W-1:0]  RW      = WA_W'(RATE_WORDS);
    localparam logic [WA_W-1:0]  LASTIDX = WA_W'(RATE_WORDS - 1);
    localparam logic [LEN_W-1:0] RW_LEN  = LEN_W'(RATE_WORDS);

    state_t          state;
    logic [LEN_W-1:0] rem;
    logic [WA_W-1:0] rcv;
    logic [WA_W-1:0] iss;
    logic [WA_W-1:0] mend;
    logic [WA_W-1:0] need;
    logic            lastblk;
    logic            wfirst;
    logic            abort;
    logic            take;
    logic [31:0]     padword;

    // Block sizing and the pad word for the current index. mend holds the
    // index right after the last message word of the final block, which is
    // where the domain-separation word goes; it may coincide with the last
    // rate index, in which case both pad bits end up in the same word.
    always_comb begin
        need    = (rem >= RW_LEN) ? RW : rem[WA_W-1:0];
        abort   = (state != IDLE) && bus.fiforderr;
        take    = (state == FILL) && bus.fifovld && (iss != rcv) && !abort;
        padword = ((rcv == mend) ? DS_PAD : 32'h0) |
                  ((rcv == LASTIDX) ? 32'h80000000 : 32'h0);
    end

    // Read requests and core writes are combinational from the registered
    // counters so a returning FIFO word lands in the rate buffer the same
    // cycle it arrives. An error cycle suppresses everything.
    always_comb begin
        bus.fifoget   = (state == FILL) && bus.fifordy && (iss < need) && !abort;
        bus.core_wr   = 1'b0;
        bus.core_wa   = rcv;
        bus.core_dat  = 32'h0;
        if (take) begin
            bus.core_wr  = 1'b1;
            bus.core_dat = bus.fifodout;
        end else if ((state == PAD) && !abort) begin
            bus.core_wr  = 1'b1;
            bus.core_dat = padword;
        end
        bus.core_go   = (state == FIRE) && !bus.core_busy && !abort;
        bus.core_last = bus.core_go && lastblk;
    end

    // Main sequencer. A block is finished once every issued read has come
    // back (rcv == need); a full block fires non-last, anything shorter
    // (including the empty block after an exact-multiple message) is padded
    // and fires last. WAITC skips its first cycle because the core may only
    // raise core_busy one cycle after core_go.
    always_ff @(posedge rdclk or posedge rdrst) begin
        if (rdrst) begin
            state     <= IDLE;
            rem       <= '0;
            rcv       <= '0;
            iss       <= '0;
            mend      <= '0;
            lastblk   <= 1'b0;
            wfirst    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            bus.flush <= 1'b0;
        end else begin
            done      <= 1'b0;
            bus.flush <= 1'b0;
            if (abort) begin
                bus.flush <= 1'b1;
                err       <= 1'b1;
                busy      <= 1'b0;
                state     <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            rem  <= msg_words;
                            err  <= 1'b0;
                            busy <= 1'b1;
                            rcv  <= '0;
                            iss  <= '0;
                            mend <= '0;
                            state <= (msg_words == '0) ? PAD : FILL;
                        end
                    end
                    FILL: begin
                        if (bus.fifoget) iss <= iss + WA_W'(1);
                        if (take) rcv <= rcv + WA_W'(1);
                        if (rcv == need) begin
                            rem <= rem - LEN_W'(need);
                            if (need == RW) begin
                                lastblk <= 1'b0;
                                state   <= FIRE;
                            end else begin
                                mend  <= rcv;
                                state <= PAD;
                            end
                        end
                    end
                    PAD: begin
                        if (rcv == LASTIDX) begin
                            lastblk <= 1'b1;
                            state   <= FIRE;
                        end else begin
                            rcv <= rcv + WA_W'(1);
                        end
                    end
                    FIRE: begin
                        if (!bus.core_busy) begin
                            if (lastblk) begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= IDLE;
                            end else begin
                                wfirst <= 1'b1;
                                state  <= WAITC;
                            end
                        end
                    end
                    WAITC: begin
                        if (wfirst) begin
                            wfirst <= 1'b0;
                        end else if (!bus.core_busy) begin
                            rcv   <= '0;
                            iss   <= '0;
                            state <= FILL;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keccak_absorb_seq.sv
// tb_keccak_absorb_seq
// Self-checking bench for keccak_absorb_seq. A FIFO model and a core model
// sit on the slave side of the interface; a monitor records every core
// write, permute and pulse. Expected streams come from the SHA-3 padding
// rule applied to the whole message as a flat word list.
module tb_keccak_absorb_seq;

    localparam int RW = 34;

    logic        rdclk = 1'b0;
    logic        rdrst;
    logic        start;
    logic [15:0] msg_words;
    logic        busy;
    logic        done;
    logic        err;

    keccak_absorb_seq_if #(.WA_W(6)) bus ();

    keccak_absorb_seq dut (
        .rdclk     (rdclk),
        .rdrst     (rdrst),
        .start     (start),
        .msg_words (msg_words),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .bus       (bus)
    );

    always #5 rdclk = ~rdclk;

    int tests  = 0;
    int failed = 0;

    // FIFO / core model state
    logic [31:0] fifoq[$];
    logic        getpend;
    logic        gosaw;
    logic        togglen;
    logic        phase;
    logic        errarm;
    int          errafter;
    int          vldcount;
    int          busycnt;

    // monitor records
    logic [5:0]  wa_q[$];
    logic [31:0] dat_q[$];
    int          golast_q[$];
    int          gopos_q[$];
    int          cyc, gocyc, donecyc;
    int          ndone, nflush, nget, nbadget, nbusywr;

    // Flat padding model: message, then DS word, zeros up to a rate
    // boundary, and the top bit of the very last word.
    function automatic void build_expected(input logic [31:0] msg[$], output logic [31:0] exp[$]);
        exp = msg;
        exp.push_back(32'h00000006);
        while ((exp.size() % RW) != 0) exp.push_back(32'h0);
        exp[exp.size()-1] = exp[exp.size()-1] | 32'h80000000;
    endfunction

    // Monitor at negedge, slave-side drive at posedge+1.
    initial begin
        bus.fifordy   = 1'b0;
        bus.fifovld   = 1'b0;
        bus.fifodout  = 32'h0;
        bus.fiforderr = 1'b0;
        bus.core_busy = 1'b0;
        getpend = 1'b0; gosaw = 1'b0; togglen = 1'b0; phase = 1'b1;
        errarm = 1'b0; errafter = 0; vldcount = 0; busycnt = 0; cyc = 0;
        forever begin
            @(negedge rdclk);
            cyc++;
            getpend = bus.fifoget;
            gosaw   = bus.core_go;
            if (bus.fifoget) begin
                nget++;
                if (!bus.fifordy) nbadget++;
            end
            if (bus.core_wr) begin
                wa_q.push_back(bus.core_wa);
                dat_q.push_back(bus.core_dat);
                if (bus.core_busy) nbusywr++;
            end
            if (bus.core_go) begin
                golast_q.push_back(int'(bus.core_last));
                gopos_q.push_back(wa_q.size());
                gocyc = cyc;
                if (bus.core_busy) nbusywr++;
            end
            if (done) begin ndone++; donecyc = cyc; end
            if (bus.flush) nflush++;
            @(posedge rdclk);
            #1;
            bus.fifovld   = 1'b0;
            bus.fiforderr = 1'b0;
            if (errarm) begin bus.fiforderr = 1'b1; errarm = 1'b0; errafter = 0; end
            if (getpend && fifoq.size() > 0) begin
                bus.fifovld  = 1'b1;
                bus.fifodout = fifoq.pop_front();
                vldcount++;
                if (errafter != 0 && vldcount == errafter) errarm = 1'b1;
            end
            phase = togglen ? ~phase : 1'b1;
            bus.fifordy = phase && (fifoq.size() > 0);
            if (gosaw) busycnt = $urandom_range(1, 4);
            if (busycnt > 0) begin bus.core_busy = 1'b1; busycnt--; end
            else bus.core_busy = 1'b0;
        end
    end

    task automatic tick();
        @(posedge rdclk);
        #2;
    endtask

    task automatic clear_mon();
        wa_q.delete(); dat_q.delete(); golast_q.delete(); gopos_q.delete();
        ndone = 0; nflush = 0; nget = 0; nbadget = 0; nbusywr = 0;
        gocyc = -100; donecyc = -100; vldcount = 0;
    endtask

    task automatic test_reset();
        rdrst = 1'b1; start = 1'b0; msg_words = '0;
        tick(); tick();
        tests++; if (busy !== 1'b0) begin failed++; $display("[TB] FAIL reset_busy: got %b need 0", busy); end
        tests++; if (done !== 1'b0) begin failed++; $display("[TB] FAIL reset_done: got %b need 0", done); end
        tests++; if (err !== 1'b0) begin failed++; $display("[TB] FAIL reset_err: got %b need 0", err); end
        tests++; if (bus.fifoget !== 1'b0 || bus.flush !== 1'b0) begin failed++; $display("[TB] FAIL reset_fifo: got get=%b flush=%b need 0 0", bus.fifoget, bus.flush); end
        tests++; if (bus.core_wr !== 1'b0 || bus.core_go !== 1'b0 || bus.core_last !== 1'b0) begin failed++; $display("[TB] FAIL reset_core: got wr=%b go=%b last=%b need 0 0 0", bus.core_wr, bus.core_go, bus.core_last); end
        tests++; if (bus.core_wa !== 6'd0 || bus.core_dat !== 32'h0) begin failed++; $display("[TB] FAIL reset_bus: got wa=%0d dat=%h need 0 0", bus.core_wa, bus.core_dat); end
        rdrst = 1'b0;
        tick();
    endtask

    // Table of message scenarios: short, pad word on last index, exact
    // multiple, multi-block with throttled FIFO, empty with a stray start,
    // and one random length.
    task automatic test_message_scenarios();
        int lens[6];
        bit togs[6];
        bit pokes[6];
        lens  = '{3, 33, 34, 70, 0, 0};
        lens[5] = $urandom_range(35, 110);
        togs  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        pokes = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int s = 0; s < 6; s++) begin
            logic [31:0] msg[$];
            logic [31:0] exp[$];
            int nblk;
            bit tmo;
            string nm;
            nm = $sformatf("len%0d", lens[s]);
            msg.delete();
            for (int j = 0; j < lens[s]; j++) msg.push_back((s == 0) ? 32'(8'h11 * (j + 1)) : $urandom);
            build_expected(msg, exp);
            nblk = exp.size() / RW;
            clear_mon();
            fifoq = msg;
            togglen = togs[s];
            msg_words = 16'(lens[s]);
            start = 1'b1;
            tick();
            start = 1'b0;
            tmo = 1'b1;
            for (int c = 0; c < 5000; c++) begin
                if (pokes[s] && c == 3) begin msg_words = 16'd5; start = 1'b1; end
                else start = 1'b0;
                tick();
                if (ndone > 0 || nflush > 0) begin tmo = 1'b0; break; end
            end
            start = 1'b0;
            tick(); tick();
            togglen = 1'b0;
            tests++; if (tmo) begin failed++; $display("[TB] FAIL %s timeout: done count %0d, need 1 within budget", nm, ndone); end
            tests++; if (wa_q.size() != exp.size()) begin failed++; $display("[TB] FAIL %s wr_count: got %0d need %0d", nm, wa_q.size(), exp.size()); end
            for (int i = 0; i < exp.size() && i < wa_q.size(); i++) begin
                tests++;
                if (wa_q[i] !== 6'(i % RW) || dat_q[i] !== exp[i]) begin
                    failed++;
                    $display("[TB] FAIL %s wr%0d: got wa=%0d dat=%h need wa=%0d dat=%h", nm, i, wa_q[i], dat_q[i], i % RW, exp[i]);
                end
            end
            tests++; if (golast_q.size() != nblk) begin failed++; $display("[TB] FAIL %s go_count: got %0d need %0d", nm, golast_q.size(), nblk); end
            for (int k = 0; k < nblk && k < golast_q.size(); k++) begin
                tests++;
                if (golast_q[k] != int'(k == nblk - 1) || gopos_q[k] != RW * (k + 1)) begin
                    failed++;
                    $display("[TB] FAIL %s go%0d: got last=%0d after %0d writes need last=%0d after %0d", nm, k, golast_q[k], gopos_q[k], int'(k == nblk - 1), RW * (k + 1));
                end
            end
            tests++; if (ndone != 1 || donecyc != gocyc + 1) begin failed++; $display("[TB] FAIL %s done: got %0d pulses at cyc %0d need 1 at cyc %0d", nm, ndone, donecyc, gocyc + 1); end
            tests++; if (nget != lens[s]) begin failed++; $display("[TB] FAIL %s fifoget_count: got %0d need %0d", nm, nget, lens[s]); end
            tests++; if (nbadget != 0) begin failed++; $display("[TB] FAIL %s get_not_ready: got %0d need 0", nm, nbadget); end
            tests++; if (nbusywr != 0) begin failed++; $display("[TB] FAIL %s core_busy_overlap: got %0d need 0", nm, nbusywr); end
            tests++; if (busy !== 1'b0 || err !== 1'b0 || nflush != 0) begin failed++; $display("[TB] FAIL %s end_state: got busy=%b err=%b flush=%0d need 0 0 0", nm, busy, err, nflush); end
            fifoq.delete();
        end
    endtask

    // FIFO read error after the fifth word of a ten-word message, then a
    // clean three-word message to show err clears on the next start.
    task automatic test_fifo_error();
        logic [31:0] msg[$];
        bit tmo;
        clear_mon();
        for (int j = 0; j < 10; j++) msg.push_back($urandom);
        fifoq = msg;
        errafter = 5;
        msg_words = 16'd10;
        start = 1'b1;
        tick();
        start = 1'b0;
        tmo = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            tick();
            if (nflush > 0) begin tmo = 1'b0; break; end
        end
        tick(); tick(); tick();
        tests++; if (tmo) begin failed++; $display("[TB] FAIL err_timeout: got no flush, need flush within budget"); end
        tests++; if (nflush != 1) begin failed++; $display("[TB] FAIL err_flush: got %0d pulses need 1", nflush); end
        tests++; if (err !== 1'b1 || busy !== 1'b0) begin failed++; $display("[TB] FAIL err_flags: got err=%b busy=%b need 1 0", err, busy); end
        tests++; if (golast_q.size() != 0 || ndone != 0) begin failed++; $display("[TB] FAIL err_no_fire: got go=%0d done=%0d need 0 0", golast_q.size(), ndone); end
        tests++; if (wa_q.size() != 5) begin failed++; $display("[TB] FAIL err_wr_count: got %0d need 5", wa_q.size()); end
        for (int i = 0; i < 5 && i < wa_q.size(); i++) begin
            tests++;
            if (wa_q[i] !== 6'(i) || dat_q[i] !== msg[i]) begin
                failed++;
                $display("[TB] FAIL err_wr%0d: got wa=%0d dat=%h need wa=%0d dat=%h", i, wa_q[i], dat_q[i], i, msg[i]);
            end
        end
        errafter = 0;
        fifoq.delete();
        tick();
        clear_mon();
        for (int j = 0; j < 3; j++) fifoq.push_back($urandom);
        msg_words = 16'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        tests++; if (err !== 1'b0 || busy !== 1'b1) begin failed++; $display("[TB] FAIL err_clear: got err=%b busy=%b need 0 1", err, busy); end
        tmo = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            tick();
            if (ndone > 0) begin tmo = 1'b0; break; end
        end
        tick();
        tests++; if (tmo || wa_q.size() != RW || golast_q.size() != 1) begin failed++; $display("[TB] FAIL err_recover: got wr=%0d go=%0d done=%0d need %0d 1 1", wa_q.size(), golast_q.size(), ndone, RW); end
        fifoq.delete();
    endtask

    // Reset in the middle of a first block: everything drops at once and no
    // permute is issued for the partial block.
    task automatic test_reset_midop();
        int nwr;
        clear_mon();
        for (int j = 0; j < 40; j++) fifoq.push_back($urandom);
        msg_words = 16'd40;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 20; c++) tick();
        tests++; if (busy !== 1'b1) begin failed++; $display("[TB] FAIL midrst_pre: got busy=%b need 1", busy); end
        rdrst = 1'b1;
        #1;
        tests++; if (busy !== 1'b0 || bus.fifoget !== 1'b0 || bus.core_wr !== 1'b0 || bus.core_go !== 1'b0) begin failed++; $display("[TB] FAIL midrst_outputs: got busy=%b get=%b wr=%b go=%b need 0 0 0 0", busy, bus.fifoget, bus.core_wr, bus.core_go); end
        nwr = wa_q.size();
        tick();
        rdrst = 1'b0;
        for (int c = 0; c < 6; c++) tick();
        tests++; if (golast_q.size() != 0 || wa_q.size() != nwr || ndone != 0) begin failed++; $display("[TB] FAIL midrst_quiet: got go=%0d wr=%0d done=%0d need 0 %0d 0", golast_q.size(), wa_q.size(), ndone, nwr); end
        fifoq.delete();
        tick();
    endtask

    initial begin
        rdrst = 1'b1;
        start = 1'b0;
        msg_words = '0;
        clear_mon();
        test_reset();
        test_message_scenarios();
        test_fifo_error();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/keccak_absorb_seq.md
Name: keccak_absorb_seq

Overview:
- Read-side sequencer between the dual-clock input FIFO and the Keccak absorb core.
- On start, pulls the message's 32-bit words from the FIFO read port and writes them into the core's rate buffer one word index at a time.
- Appends SHA-3 word-granular padding and fires the permutation once per rate block.
- Runs entirely in the FIFO read clock domain.

Parameters:
RATE_WORDS, 34, words per rate block (1088-bit rate, SHA3-256)
WA_W, 6, width of core word address
LEN_W, 16, width of message length in words
DS_PAD, 32'h00000006, domain-separation/pad word written at message end

Ports:
rdclk  in  1  clock
rdrst  in  1  reset; asynchronous, active-high
start  in  1  one-cycle request to hash a message; ignored unless idle
msg_words  in  LEN_W  message length in 32-bit words, sampled with start
busy  out  1  high from accepted start until done or error
done  out  1  one-cycle pulse when the final block has been fired
err  out  1  sticky FIFO read error; cleared by next accepted start
fifordy  in  1  FIFO has a word available
fifoget  out  1  read request, one word per cycle asserted
fifovld  in  1  read data valid, exactly 1 cycle after fifoget
fifodout  in  32  read data
fiforderr  in  1  FIFO read-side error
flush  out  1  one-cycle FIFO flush pulse on error abort
core_wr  out  1  write core_dat to rate buffer word core_wa
core_wa  out  WA_W  rate buffer word index, 0..RATE_WORDS-1
core_dat  out  32  word to absorb
core_go  out  1  one-cycle pulse: XOR buffer into state and permute
core_last  out  1  qualifies core_go: final block of message
core_busy  in  1  core permuting; asserted no later than 1 cycle after core_go

Behaviour:
- Reset: state IDLE; all outputs 0; counters 0.
- States: IDLE, FILL, PAD, FIRE, WAITC.
- IDLE: on start, latch rem = msg_words, clear err, set busy = 1, rcv = iss = 0.
  - rem >= 1: go FILL.
  - rem == 0: go PAD.
- Per block: need = min(rem, RATE_WORDS).
- FILL:
  - fifoget = fifordy && iss < need. Back-to-back reads allowed; iss++ per fifoget.
  - On fifovld: core_wr = 1, core_wa = rcv, core_dat = fifodout (same cycle, combinational from registered counters), rcv++.
  - fifovld with iss == rcv (nothing outstanding) is ignored.
  - When rcv reaches need, rem -= need.
    - need == RATE_WORDS: go FIRE, non-last.
    - need < RATE_WORDS: go PAD.
- PAD: one core_wr per cycle for indices rcv..RATE_WORDS-1.
  - Index equal to the message-end index: DS_PAD.
  - Other indices: 0.
  - Index RATE_WORDS-1: additionally OR 32'h80000000. If the pad word is also the last index, write 32'h80000006.
  - Then go FIRE, last.
- Message length an exact multiple of RATE_WORDS (including 0): the final message block fires non-last, and a full pad block follows (word 0 = DS_PAD, word 33 = 32'h80000000).
- FIRE: wait for core_busy == 0, then pulse core_go for one cycle with core_last.
  - Last: pulse done, busy = 0, go IDLE.
  - Otherwise: go WAITC.
- WAITC: ignore core_busy in the first cycle. Then wait for core_busy == 0, reset rcv = iss = 0, go FILL.
- No core_wr is issued while core_busy may be high.
- Error: fiforderr high in any non-IDLE state takes priority over all other events that cycle.
  - Pulse flush for one cycle, set err = 1, busy = 0, go IDLE.
  - In-flight fifovld data is discarded, no core_wr.
  - No done pulse, no core_go.
  - fiforderr in IDLE is ignored.
- start while busy: ignored; no effect on counters.
- Reset mid-operation: immediate return to reset state. core_go is not emitted for a partial block.

Test Plan:
- msg_words = 3, FIFO preloaded 0x11,0x22,0x33 → core_wr at wa 0..2 with those values, wa 3 = 0x00000006, wa 4..32 = 0, wa 33 = 0x80000000; one core_go with core_last = 1; done 1 cycle after core_go.
- msg_words = 33 → wa 33 written as 0x80000006; a single block fires, last.
- msg_words = 34 → first core_go has core_last = 0; after core_busy drops, second block: wa 0 = 0x00000006, wa 33 = 0x80000000, core_last = 1; exactly 68 core_wr in total.
- msg_words = 70 with fifordy toggling every other cycle → no fifoget while fifordy = 0; 3 core_go pulses (last only on third); word order preserved.
- fiforderr asserted after the 5th fifovld of a 10-word message → flush pulses once, err = 1, busy = 0, no core_go, no done; next start clears err.
- msg_words = 0 → zero fifoget; full pad block written; core_go with core_last = 1; start asserted while busy → no effect.
